// File: rtl/arp_req_arb.sv
// arp_req_arb
//   Round-robin arbiter that shares the single arp request/response port
//   among S_COUNT requesters. It owns one lookup at a time: it latches the
//   winning request, forwards it to arp, and routes the response back to the
//   granted requester only.
//
//   Optional watchdog, enabled by defining ARP_REQ_ARB_TIMEOUT_EN. This adds
//   the timeout_cycles port and converts a stuck lookup into an error
//   response. Any arp response still owed after that is drained and dropped.
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   s_arp_request_*         per-requester request (valid/ready/ip slice i)
//   s_arp_response_*        per-requester response valid/ready, shared error/mac
//   m_arp_request_*         request toward arp (valid/ready/latched ip)
//   m_arp_response_*        response from arp (valid/ready/error/mac)
//   timeout_cycles          watchdog limit, 0 disables (macro builds only)
//   busy                    arbiter is not idle
//   grant_index             index of the current or last grant
module arp_req_arb #(
   parameter int unsigned S_COUNT       = 2,
   parameter int unsigned TIMEOUT_WIDTH = 24
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [S_COUNT-1:0]      s_arp_request_valid,
   output logic [S_COUNT-1:0]      s_arp_request_ready,
   input  logic [S_COUNT*32-1:0]   s_arp_request_ip,
   output logic [S_COUNT-1:0]      s_arp_response_valid,
   input  logic [S_COUNT-1:0]      s_arp_response_ready,
   output logic                    s_arp_response_error,
   output logic [47:0]             s_arp_response_mac,
   output logic                    m_arp_request_valid,
   input  logic                    m_arp_request_ready,
   output logic [31:0]             m_arp_request_ip,
   input  logic                    m_arp_response_valid,
   output logic                    m_arp_response_ready,
   input  logic                    m_arp_response_error,
   input  logic [47:0]             m_arp_response_mac,
`ifdef ARP_REQ_ARB_TIMEOUT_EN
   input  logic [TIMEOUT_WIDTH-1:0] timeout_cycles,
`endif
   output logic                    busy,
   output logic [2:0]              grant_index
);

   if (S_COUNT < 2 || S_COUNT > 8 || TIMEOUT_WIDTH < 1) begin : g_bad_params
      $error("arp_req_arb: S_COUNT must be 2..8 and TIMEOUT_WIDTH at least 1");
   end

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_REQ,
      ST_RESP
`ifdef ARP_REQ_ARB_TIMEOUT_EN
      ,
      ST_ERR,
      ST_DRAIN
`endif
   } state_t;

   state_t        state_q, state_d;
   logic [31:0]   ip_q, ip_d;
   logic [2:0]    grant_q, grant_d;
   logic [2:0]    rr_ptr_q, rr_ptr_d;

   logic               hi_found, lo_found, win_found;
   logic [2:0]         hi_idx, lo_idx, win_idx;
   logic [31:0]        win_ip;
   logic [S_COUNT-1:0] win_oh, grant_oh;
   logic               gnt_resp_ready;
   logic [2:0]         ptr_after_grant;

`ifdef ARP_REQ_ARB_TIMEOUT_EN
   logic [TIMEOUT_WIDTH-1:0] cnt_q, cnt_d;
   logic                     owed_q, owed_d;
   logic                     timeout_hit;

   assign timeout_hit = (timeout_cycles != '0) && (cnt_q == timeout_cycles);
`endif

   // Round-robin pick: the lowest valid index at or above rr_ptr wins;
   // if there is none, wrap around to the lowest valid index overall.
   always_comb begin
      hi_found       = 1'b0;
      lo_found       = 1'b0;
      hi_idx         = '0;
      lo_idx         = '0;
      win_ip         = '0;
      win_oh         = '0;
      grant_oh       = '0;
      gnt_resp_ready = 1'b0;
      for (int unsigned i = 0; i < S_COUNT; i++) begin
         if (s_arp_request_valid[i]) begin
            if (!lo_found) begin
               lo_found = 1'b1;
               lo_idx   = 3'(i);
            end
            if (!hi_found && (3'(i) >= rr_ptr_q)) begin
               hi_found = 1'b1;
               hi_idx   = 3'(i);
            end
         end
      end
      win_found = hi_found | lo_found;
      win_idx   = hi_found ? hi_idx : lo_idx;
      for (int unsigned i = 0; i < S_COUNT; i++) begin
         if (3'(i) == win_idx) begin
            win_oh[i] = win_found;
            win_ip    = s_arp_request_ip[32*i +: 32];
         end
         if (3'(i) == grant_q) begin
            grant_oh[i]    = 1'b1;
            gnt_resp_ready = s_arp_response_ready[i];
         end
      end
      ptr_after_grant = (grant_q == 3'(S_COUNT - 1)) ? 3'd0 : grant_q + 3'd1;
   end

   always_comb begin
      state_d              = state_q;
      ip_d                 = ip_q;
      grant_d              = grant_q;
      rr_ptr_d             = rr_ptr_q;
      s_arp_request_ready  = '0;
      s_arp_response_valid = '0;
      s_arp_response_error = 1'b0;
      s_arp_response_mac   = '0;
      m_arp_request_valid  = 1'b0;
      m_arp_response_ready = 1'b0;
`ifdef ARP_REQ_ARB_TIMEOUT_EN
      cnt_d                = cnt_q;
      owed_d               = owed_q;
`endif
      case (state_q)
         ST_IDLE: begin
            s_arp_request_ready = win_oh;
            if (win_found) begin
               ip_d    = win_ip;
               grant_d = win_idx;
               state_d = ST_REQ;
`ifdef ARP_REQ_ARB_TIMEOUT_EN
               cnt_d   = '0;
               owed_d  = 1'b0;
`endif
            end
         end
         ST_REQ: begin
            m_arp_request_valid = 1'b1;
`ifdef ARP_REQ_ARB_TIMEOUT_EN
            // A request accepted in the same cycle as the timeout still
            // produces an arp response, which has to be drained later.
            if (timeout_hit) begin
               state_d = ST_ERR;
               owed_d  = m_arp_request_ready;
            end else begin
               cnt_d = cnt_q + 1'b1;
               if (m_arp_request_ready) state_d = ST_RESP;
            end
`else
            if (m_arp_request_ready) state_d = ST_RESP;
`endif
         end
         ST_RESP: begin
            s_arp_response_valid = grant_oh & {S_COUNT{m_arp_response_valid}};
            s_arp_response_error = m_arp_response_error;
            s_arp_response_mac   = m_arp_response_mac;
            m_arp_response_ready = gnt_resp_ready;
            if (m_arp_response_valid && gnt_resp_ready) begin
               rr_ptr_d = ptr_after_grant;
               state_d  = ST_IDLE;
            end
`ifdef ARP_REQ_ARB_TIMEOUT_EN
            else if (timeout_hit) begin
               state_d = ST_ERR;
               owed_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
`endif
         end
`ifdef ARP_REQ_ARB_TIMEOUT_EN
         ST_ERR: begin
            s_arp_response_valid = grant_oh;
            s_arp_response_error = 1'b1;
            if (gnt_resp_ready) begin
               rr_ptr_d = ptr_after_grant;
               state_d  = owed_q ? ST_DRAIN : ST_IDLE;
            end
         end
         ST_DRAIN: begin
            m_arp_response_ready = 1'b1;
            if (m_arp_response_valid) state_d = ST_IDLE;
         end
`endif
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         ip_q     <= '0;
         grant_q  <= '0;
         rr_ptr_q <= '0;
`ifdef ARP_REQ_ARB_TIMEOUT_EN
         cnt_q    <= '0;
         owed_q   <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         ip_q     <= ip_d;
         grant_q  <= grant_d;
         rr_ptr_q <= rr_ptr_d;
`ifdef ARP_REQ_ARB_TIMEOUT_EN
         cnt_q    <= cnt_d;
         owed_q   <= owed_d;
`endif
      end
   end

   assign m_arp_request_ip = ip_q;
   assign busy             = (state_q != ST_IDLE);
   assign grant_index      = grant_q;

endmodule

// File: tb/tb_arp_req_arb.sv
module tb_arp_req_arb;
   localparam logic [31:0] IPA  = 32'h0A000002;
   localparam logic [31:0] IPB  = 32'hC0A80163;
   localparam logic [47:0] MACA = 48'h001122334455;
   localparam logic [47:0] MACB = 48'hAABBCCDDEEFF;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n = 1'b1;
   logic [1:0]  rv = '0, rr = '0;
   logic [63:0] ip = '0;
   logic        mrr = 1'b0, mrv = 1'b0, merr = 1'b0;
   logic [47:0] mmac = '0;

   logic [1:0]  rq, rsv;
   logic        rerr, mreqv, mrespr, busy;
   logic [47:0] rmac;
   logic [31:0] mip;
   logic [2:0]  gnt;

   int nvec = 0;
   int nerr = 0;

`ifdef ARP_REQ_ARB_TIMEOUT_EN
   logic [23:0] tmo = '0;
`endif

   arp_req_arb #(.S_COUNT(2), .TIMEOUT_WIDTH(24)) dut (
      .clk                  (clk),
      .rst_n                (rst_n),
      .s_arp_request_valid  (rv),
      .s_arp_request_ready  (rq),
      .s_arp_request_ip     (ip),
      .s_arp_response_valid (rsv),
      .s_arp_response_ready (rr),
      .s_arp_response_error (rerr),
      .s_arp_response_mac   (rmac),
      .m_arp_request_valid  (mreqv),
      .m_arp_request_ready  (mrr),
      .m_arp_request_ip     (mip),
      .m_arp_response_valid (mrv),
      .m_arp_response_ready (mrespr),
      .m_arp_response_error (merr),
      .m_arp_response_mac   (mmac),
`ifdef ARP_REQ_ARB_TIMEOUT_EN
      .timeout_cycles       (tmo),
`endif
      .busy                 (busy),
      .grant_index          (gnt)
   );

   typedef struct {
      logic        rst;
      logic [1:0]  rv;
      logic [31:0] ip0, ip1;
      logic [1:0]  rr;
      logic        mrr, mrv, merr;
      logic [47:0] mmac;
      logic [1:0]  e_rq, e_rsv;
      logic        e_err;
      logic [47:0] e_mac;
      logic        e_mreqv;
      logic [31:0] e_mip;
      logic        e_mrespr, e_busy;
      logic [2:0]  e_gnt;
   } vec_t;

   vec_t tv[$];

   task automatic add(input logic r, input logic [1:0] v, input logic [31:0] i0, input logic [31:0] i1,
                      input logic [1:0] rdy, input logic a_rr, input logic a_rv, input logic a_err,
                      input logic [47:0] a_mac, input logic [1:0] x_rq, input logic [1:0] x_rsv,
                      input logic x_err, input logic [47:0] x_mac, input logic x_mreqv,
                      input logic [31:0] x_mip, input logic x_mrespr, input logic x_busy,
                      input logic [2:0] x_gnt);
      vec_t t;
      t = '{r, v, i0, i1, rdy, a_rr, a_rv, a_err, a_mac,
            x_rq, x_rsv, x_err, x_mac, x_mreqv, x_mip, x_mrespr, x_busy, x_gnt};
      tv.push_back(t);
   endtask

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic set_in(input logic [1:0] v, input logic [31:0] i0, input logic [31:0] i1,
                         input logic [1:0] rdy, input logic a_rr, input logic a_rv,
                         input logic a_err, input logic [47:0] a_mac);
      rv = v; ip = {i1, i0}; rr = rdy; mrr = a_rr; mrv = a_rv; merr = a_err; mmac = a_mac;
   endtask

   initial begin
      //  rst rv     ip0  ip1  rr     mrr mrv err mac  | rq     rsv    err mac  mreqv mip  mrespr busy gnt
      add(0, 2'b00, 0,   0,   2'b00, 0,  0,  0,  0,    2'b00, 2'b00, 0,  0,   0,    0,   0,     0,   0); // reset
      // single lookup by requester 0, arp ready after 2 cycles
      add(1, 2'b01, IPA, 0,   2'b00, 0,  0,  0,  0,    2'b01, 2'b00, 0,  0,   0,    0,   0,     0,   0);
      add(1, 2'b00, IPA, 0,   2'b00, 0,  0,  0,  0,    2'b00, 2'b00, 0,  0,   1,    IPA, 0,     1,   0);
      add(1, 2'b00, IPA, 0,   2'b11, 0,  1,  0,  MACA, 2'b00, 2'b00, 0,  0,   1,    IPA, 0,     1,   0);
      add(1, 2'b00, IPA, 0,   2'b00, 1,  0,  0,  0,    2'b00, 2'b00, 0,  0,   1,    IPA, 0,     1,   0);
      add(1, 2'b00, 0,   0,   2'b01, 0,  0,  0,  0,    2'b00, 2'b00, 0,  0,   0,    IPA, 1,     1,   0);
      add(1, 2'b00, 0,   0,   2'b01, 0,  1,  0,  MACA, 2'b00, 2'b01, 0,  MACA, 0,   IPA, 1,     1,   0);
      add(1, 2'b00, 0,   0,   2'b00, 0,  0,  0,  0,    2'b00, 2'b00, 0,  0,   0,    IPA, 0,     0,   0);
      // contention right after requester 0 was served: requester 1 wins
      add(1, 2'b11, IPA, IPB, 2'b00, 0,  0,  0,  0,    2'b10, 2'b00, 0,  0,   0,    IPA, 0,     0,   0);
      add(1, 2'b01, IPA, IPB, 2'b00, 1,  0,  0,  0,    2'b00, 2'b00, 0,  0,   1,    IPB, 0,     1,   1);
      // response backpressure from requester 1 for 5 cycles
      for (int k = 0; k < 5; k++)
         add(1, 2'b01, IPA, IPB, 2'b00, 0, 1, 0, MACB, 2'b00, 2'b10, 0, MACB, 0,    IPB, 0,     1,   1);
      add(1, 2'b00, IPA, IPB, 2'b10, 0,  1,  0,  MACB, 2'b00, 2'b10, 0,  MACB, 0,   IPB, 1,     1,   1);
      // error passthrough; pointer wrapped to 0 but only requester 1 asks
      add(1, 2'b10, 0,   IPB, 2'b00, 0,  0,  0,  0,    2'b10, 2'b00, 0,  0,   0,    IPB, 0,     0,   1);
      add(1, 2'b00, 0,   IPB, 2'b00, 1,  0,  0,  0,    2'b00, 2'b00, 0,  0,   1,    IPB, 0,     1,   1);
      add(1, 2'b00, 0,   IPB, 2'b10, 0,  1,  1,  0,    2'b00, 2'b10, 1,  0,   0,    IPB, 1,     1,   1);
      add(1, 2'b00, 0,   0,   2'b00, 0,  0,  0,  0,    2'b00, 2'b00, 0,  0,   0,    IPB, 0,     0,   1);
      // reset in the middle of a response, then contention from reset
      add(1, 2'b11, IPA, IPB, 2'b00, 0,  0,  0,  0,    2'b01, 2'b00, 0,  0,   0,    IPB, 0,     0,   1);
      add(1, 2'b10, IPA, IPB, 2'b00, 1,  0,  0,  0,    2'b00, 2'b00, 0,  0,   1,    IPA, 0,     1,   0);
      add(1, 2'b10, IPA, IPB, 2'b00, 0,  1,  0,  MACA, 2'b00, 2'b01, 0,  MACA, 0,   IPA, 0,     1,   0);
      add(0, 2'b00, IPA, IPB, 2'b00, 0,  1,  0,  MACA, 2'b00, 2'b00, 0,  0,   0,    0,   0,     0,   0);
      add(1, 2'b11, IPA, IPB, 2'b00, 0,  0,  0,  0,    2'b01, 2'b00, 0,  0,   0,    0,   0,     0,   0);
      add(1, 2'b10, IPA, IPB, 2'b00, 1,  0,  0,  0,    2'b00, 2'b00, 0,  0,   1,    IPA, 0,     1,   0);
      add(1, 2'b10, IPA, IPB, 2'b01, 0,  1,  0,  MACA, 2'b00, 2'b01, 0,  MACA, 0,   IPA, 1,     1,   0);
      add(1, 2'b10, IPA, IPB, 2'b00, 0,  0,  0,  0,    2'b10, 2'b00, 0,  0,   0,    IPA, 0,     0,   0);
      add(1, 2'b00, IPA, IPB, 2'b00, 1,  0,  0,  0,    2'b00, 2'b00, 0,  0,   1,    IPB, 0,     1,   1);
      add(1, 2'b00, IPA, IPB, 2'b10, 0,  1,  0,  MACB, 2'b00, 2'b10, 0,  MACB, 0,   IPB, 1,     1,   1);
      add(1, 2'b00, 0,   0,   2'b00, 0,  0,  0,  0,    2'b00, 2'b00, 0,  0,   0,    IPB, 0,     0,   1);

      foreach (tv[i]) begin
         @(negedge clk);
         rst_n = tv[i].rst;
         set_in(tv[i].rv, tv[i].ip0, tv[i].ip1, tv[i].rr, tv[i].mrr, tv[i].mrv, tv[i].merr, tv[i].mmac);
         #1;
         chk($sformatf("vec%0d", i),
             128'({rq, rsv, rerr, rmac, mreqv, mip, mrespr, busy, gnt}),
             128'({tv[i].e_rq, tv[i].e_rsv, tv[i].e_err, tv[i].e_mac, tv[i].e_mreqv,
                   tv[i].e_mip, tv[i].e_mrespr, tv[i].e_busy, tv[i].e_gnt}));
      end

`ifdef ARP_REQ_ARB_TIMEOUT_EN
      begin
         int n;
         // watchdog at 100: arp accepts but withholds its response
         tmo = 24'd100;
         @(negedge clk); set_in(2'b01, IPA, 0, 2'b00, 0, 0, 0, 0); #1;
         chk("wd_accept", 128'(rq), 128'(2'b01));
         @(negedge clk); set_in(2'b00, IPA, 0, 2'b00, 1, 0, 0, 0);
         n = 1;
         do begin
            @(negedge clk); set_in(2'b00, 0, 0, 2'b00, 0, 0, 0, 0); n++; #1;
         end while (rsv == 2'b00 && n < 400);
         chk("wd_err_cycle", 128'(n), 128'(102));
         chk("wd_err_resp", 128'({rsv, rerr, rmac}), 128'({2'b01, 1'b1, 48'h0}));
         rr = 2'b01;
         @(negedge clk); set_in(2'b00, 0, 0, 2'b00, 0, 0, 0, 0); n++; #1;
         chk("wd_drain", 128'({rsv, mrespr, busy}), 128'({2'b00, 1'b1, 1'b1}));
         while (n < 300) begin
            @(negedge clk); n++;
         end
         set_in(2'b00, 0, 0, 2'b01, 0, 1, 0, MACA); #1;
         chk("wd_stale", 128'({rsv, mrespr}), 128'({2'b00, 1'b1}));
         @(negedge clk); set_in(2'b00, 0, 0, 2'b00, 0, 0, 0, 0); #1;
         chk("wd_idle", 128'({busy, rsv}), 128'({1'b0, 2'b00}));
         // watchdog disabled: a 150-cycle stall is simply waited out
         tmo = 24'd0;
         @(negedge clk); set_in(2'b10, 0, IPB, 2'b00, 0, 0, 0, 0); #1;
         chk("wd0_accept", 128'(rq), 128'(2'b10));
         @(negedge clk); set_in(2'b00, 0, IPB, 2'b00, 1, 0, 0, 0);
         n = 0;
         for (int k = 0; k < 150; k++) begin
            @(negedge clk); set_in(2'b00, 0, 0, 2'b10, 0, 0, 0, 0); #1;
            if (rsv != 2'b00 || !busy) n++;
         end
         chk("wd0_no_timeout", 128'(n), 128'(0));
         @(negedge clk); set_in(2'b00, 0, 0, 2'b10, 0, 1, 0, MACB); #1;
         chk("wd0_resp", 128'({rsv, rerr, rmac}), 128'({2'b10, 1'b0, MACB}));
         @(negedge clk); set_in(2'b00, 0, 0, 2'b00, 0, 0, 0, 0); #1;
         chk("wd0_idle", 128'(busy), 128'(0));
      end
`endif

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
